// File: rtl/br_resolve_unit_pkg.sv
// pbp_types: types shared by the branch resolution unit and the perceptron
// branch predictor (pbp) training interface.
//   PBP_W_BITS   : width of the signed perceptron output carried in a request
//   theta()      : perceptron training threshold for a given history length
//   pbp_train_t  : one training request {pc, taken, y_out}
//   resolve_state_t : resolution FSM states
package pbp_types;

  localparam int PBP_W_BITS = 8;

  // Classic perceptron threshold: floor(1.93*h + 14), in integer arithmetic.
  function automatic int theta(input int hist_len);
    return (193 * hist_len) / 100 + 14;
  endfunction

  typedef struct packed {
    logic [31:0]                  pc;
    logic                         taken;
    logic signed [PBP_W_BITS-1:0] y_out;
  } pbp_train_t;

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } resolve_state_t;

endpackage

// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I opcode encoding used by the EX/MEM stage.
// Only the opcode enum is needed by the branch resolution slice.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } opcode_t;

endpackage

// File: rtl/br_resolve_unit_train_fifo.sv
// train_fifo: small synchronous FIFO of perceptron training requests.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_push/i_data : enqueue request (dropped when full unless a pop coincides)
//   o_valid/o_data: head entry, read combinationally from storage
//   i_ready       : consumer accepts head (pop on o_valid & i_ready)
//   o_drop        : pulses when a push is discarded because the queue is full
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module train_fifo
  import pbp_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  pbp_train_t i_data,
  input  logic       i_ready,
  output logic       o_valid,
  output pbp_train_t o_data,
  output logic       o_drop
);

  localparam int AW = $clog2(DEPTH);

  pbp_train_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_pop;
  logic w_wr;

  assign o_valid = (r_count != '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = o_valid & i_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_wr    = i_push & (~w_full | w_pop);
  assign o_drop  = i_push & w_full & ~w_pop;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage is cleared on reset so the head outputs read zero while empty.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          r_mem[gi] <= '0;
        end else if (w_wr && (r_wr_ptr == AW'(gi))) begin
          r_mem[gi] <= i_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/br_resolve_unit.sv
// br_resolve_unit: EX/MEM branch resolution and perceptron training source.
// Compares the actual outcome of a branch/jump against the prediction carried
// down the pipe, raises a one-cycle registered flush/redirect and BTB update on
// a misprediction, and queues training requests for the pbp predictor.
// Ports:
//   exmem_*         : EX/MEM instruction, actual outcome and carried prediction
//   flush/redirect_pc : registered squash pulse and fetch redirect
//   btb_wr*         : registered BTB update for taken mispredictions
//   train_*         : valid/ready training stream (head of the training FIFO)
// Optional: define BR_RESOLVE_PERF_EN to add saturating counters n_branches,
// n_dir_miss, n_tgt_miss and n_train_drop as 32-bit output ports.
// w_bits must equal pbp_types::PBP_W_BITS (the training request width).
module br_resolve_unit
  import rv32i_types::*;
  import pbp_types::*;
#(
  parameter int w_bits   = PBP_W_BITS,
  parameter int hist_len = 12,
  parameter int q_depth  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exmem_valid,
  input  logic [31:0]       exmem_pc,
  input  opcode_t           exmem_opcode,
  input  logic              exmem_br_en,
  input  logic [31:0]       exmem_alu_out,
  input  logic              exmem_bp_br_en,
  input  logic [31:0]       exmem_bp_target,
  input  logic [w_bits-1:0] exmem_y_out,
  output logic              flush,
  output logic [31:0]       redirect_pc,
  output logic              btb_wr,
  output logic [31:0]       btb_wr_pc,
  output logic [31:0]       btb_wr_target,
`ifdef BR_RESOLVE_PERF_EN
  output logic [31:0]       n_branches,
  output logic [31:0]       n_dir_miss,
  output logic [31:0]       n_tgt_miss,
  output logic [31:0]       n_train_drop,
`endif
  output logic              train_valid,
  input  logic              train_ready,
  output logic [31:0]       train_pc,
  output logic              train_taken,
  output logic [w_bits-1:0] train_y_out
);

  localparam logic [31:0] THETA = 32'(theta(hist_len));

  resolve_state_t r_state;
  resolve_state_t w_state_next;

  logic              w_is_br;
  logic              w_eval;
  logic              w_act;
  logic              w_dir_miss;
  logic              w_tgt_miss;
  logic              w_miss;
  logic signed [w_bits:0] w_y_ext;
  logic [w_bits:0]   w_y_abs;
  logic              w_low_conf;
  logic              w_push;
  logic              w_drop;
  pbp_train_t        w_push_data;
  pbp_train_t        w_head;

  assign w_is_br = (exmem_opcode == op_br);
  // The instruction right behind a flush is wrong-path; SHADOW masks it.
  assign w_eval  = exmem_valid && (r_state == RUN) &&
                   (w_is_br || exmem_opcode == op_jal || exmem_opcode == op_jalr);
  assign w_act   = w_is_br ? exmem_br_en : 1'b1;

  assign w_dir_miss = w_eval && (w_act != exmem_bp_br_en);
  assign w_tgt_miss = w_eval && w_act && exmem_bp_br_en &&
                      (exmem_alu_out != exmem_bp_target);
  assign w_miss     = w_dir_miss || w_tgt_miss;

  // One extra bit so |-2^(w_bits-1)| is representable.
  assign w_y_ext    = (w_bits+1)'($signed(exmem_y_out));
  assign w_y_abs    = w_y_ext[w_bits] ? 32'(-w_y_ext) : w_y_ext;
  assign w_low_conf = (32'(w_y_abs) <= THETA);

  // Target-only misses never train: direction was right and confidence is
  // judged on direction alone.
  assign w_push = w_eval && w_is_br && (w_dir_miss || w_low_conf);

  assign w_push_data.pc    = exmem_pc;
  assign w_push_data.taken = exmem_br_en;
  assign w_push_data.y_out = exmem_y_out;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = RUN;
    if (r_state == RUN && w_miss) w_state_next = SHADOW;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush         <= 1'b0;
      redirect_pc   <= '0;
      btb_wr        <= 1'b0;
      btb_wr_pc     <= '0;
      btb_wr_target <= '0;
    end else begin
      flush  <= w_miss;
      btb_wr <= w_miss && w_act;
      if (w_miss) redirect_pc <= w_act ? exmem_alu_out : exmem_pc + 32'd4;
      if (w_miss && w_act) begin
        btb_wr_pc     <= exmem_pc;
        btb_wr_target <= exmem_alu_out;
      end
    end
  end

  train_fifo #(
    .DEPTH (q_depth)
  ) u_train_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_ready (train_ready),
    .o_valid (train_valid),
    .o_data  (w_head),
    .o_drop  (w_drop)
  );

  assign train_pc    = w_head.pc;
  assign train_taken = w_head.taken;
  assign train_y_out = w_head.y_out;

`ifdef BR_RESOLVE_PERF_EN
  logic [3:0]  w_inc;
  logic [31:0] r_cnt [4];

  assign w_inc = {w_drop, w_tgt_miss, w_dir_miss, w_eval};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_perf
      always_ff @(posedge clk) begin
        if (rst)                                r_cnt[gi] <= '0;
        else if (w_inc[gi] && r_cnt[gi] != '1)  r_cnt[gi] <= r_cnt[gi] + 32'd1;
      end
    end
  endgenerate

  assign n_branches   = r_cnt[0];
  assign n_dir_miss   = r_cnt[1];
  assign n_tgt_miss   = r_cnt[2];
  assign n_train_drop = r_cnt[3];
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif

endmodule

// File: tb/tb_br_resolve_unit.sv
module tb_br_resolve_unit;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        exmem_valid;
  logic [31:0] exmem_pc;
  opcode_t     exmem_opcode;
  logic        exmem_br_en;
  logic [31:0] exmem_alu_out;
  logic        exmem_bp_br_en;
  logic [31:0] exmem_bp_target;
  logic [7:0]  exmem_y_out;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        btb_wr;
  logic [31:0] btb_wr_pc;
  logic [31:0] btb_wr_target;
  logic        train_valid;
  logic        train_ready;
  logic [31:0] train_pc;
  logic        train_taken;
  logic [7:0]  train_y_out;
`ifdef BR_RESOLVE_PERF_EN
  logic [31:0] n_branches, n_dir_miss, n_tgt_miss, n_train_drop;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  br_resolve_unit dut (
    .clk             (clk),
    .rst             (rst),
    .exmem_valid     (exmem_valid),
    .exmem_pc        (exmem_pc),
    .exmem_opcode    (exmem_opcode),
    .exmem_br_en     (exmem_br_en),
    .exmem_alu_out   (exmem_alu_out),
    .exmem_bp_br_en  (exmem_bp_br_en),
    .exmem_bp_target (exmem_bp_target),
    .exmem_y_out     (exmem_y_out),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .btb_wr          (btb_wr),
    .btb_wr_pc       (btb_wr_pc),
    .btb_wr_target   (btb_wr_target),
`ifdef BR_RESOLVE_PERF_EN
    .n_branches      (n_branches),
    .n_dir_miss      (n_dir_miss),
    .n_tgt_miss      (n_tgt_miss),
    .n_train_drop    (n_train_drop),
`endif
    .train_valid     (train_valid),
    .train_ready     (train_ready),
    .train_pc        (train_pc),
    .train_taken     (train_taken),
    .train_y_out     (train_y_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Present one instruction for one clock edge, then return to idle.
  task automatic issue(input opcode_t opc, input logic [31:0] pc, input logic br,
                       input logic [31:0] alu, input logic bp, input logic [31:0] bpt,
                       input logic [7:0] y);
    exmem_valid     = 1'b1;
    exmem_opcode    = opc;
    exmem_pc        = pc;
    exmem_br_en     = br;
    exmem_alu_out   = alu;
    exmem_bp_br_en  = bp;
    exmem_bp_target = bpt;
    exmem_y_out     = y;
    @(posedge clk); #1;
    exmem_valid     = 1'b0;
  endtask

  task automatic idle();
    exmem_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Check the head against an expected entry, then pop it.
  task automatic pop_expect(input logic [31:0] pc, input logic tk, input logic [7:0] y);
    train_ready = 1'b1;
    chk("head_valid", {31'd0, train_valid}, 32'd1);
    chk("head_pc", train_pc, pc);
    chk("head_taken", {31'd0, train_taken}, {31'd0, tk});
    chk("head_y", {24'd0, train_y_out}, {24'd0, y});
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; train_ready = 1'b0; exmem_valid = 1'b0; exmem_opcode = op_br;
    exmem_pc = '0; exmem_br_en = 1'b0; exmem_alu_out = '0; exmem_bp_br_en = 1'b0;
    exmem_bp_target = '0; exmem_y_out = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    chk("rst_btb_wr", {31'd0, btb_wr}, 32'd0);
    chk("rst_btb_pc", btb_wr_pc, 32'd0);
    chk("rst_btb_tgt", btb_wr_target, 32'd0);
    chk("rst_train_valid", {31'd0, train_valid}, 32'd0);
    chk("rst_train_pc", train_pc, 32'd0);
    chk("rst_train_taken", {31'd0, train_taken}, 32'd0);
    chk("rst_train_y", {24'd0, train_y_out}, 32'd0);
    rst = 1'b0;

    // Direction miss, actually taken.
    issue(op_br, 32'h5c, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 8'h01);
    chk("dm_flush", {31'd0, flush}, 32'd1);
    chk("dm_redirect", redirect_pc, 32'hDEADBEEF);
    chk("dm_btb_wr", {31'd0, btb_wr}, 32'd1);
    chk("dm_btb_pc", btb_wr_pc, 32'h5c);
    chk("dm_btb_tgt", btb_wr_target, 32'hDEADBEEF);
    chk("dm_train_valid", {31'd0, train_valid}, 32'd1);
    chk("dm_train_pc", train_pc, 32'h5c);

    // Wrong-path instruction in the shadow cycle: must be ignored.
    issue(op_br, 32'h80, 1'b1, 32'h100, 1'b0, 32'h0, 8'h00);
    chk("shadow_flush", {31'd0, flush}, 32'd0);
    chk("shadow_btb_wr", {31'd0, btb_wr}, 32'd0);

    // Target miss, high confidence: no training.
    issue(op_br, 32'h60, 1'b1, 32'hDEADA55B, 1'b1, 32'hDEADBEEF, 8'h41);
    chk("tm_flush", {31'd0, flush}, 32'd1);
    chk("tm_redirect", redirect_pc, 32'hDEADA55B);
    chk("tm_btb_wr", {31'd0, btb_wr}, 32'd1);
    chk("tm_btb_pc", btb_wr_pc, 32'h60);
    chk("tm_btb_tgt", btb_wr_target, 32'hDEADA55B);
    idle();
    chk("tm_flush_pulse", {31'd0, flush}, 32'd0);

    // Correct, low confidence (-10): trains, no flush.
    issue(op_br, 32'h68, 1'b1, 32'h1000, 1'b1, 32'h1000, 8'hF6);
    chk("lc_flush", {31'd0, flush}, 32'd0);
    chk("lc_btb_wr", {31'd0, btb_wr}, 32'd0);

    // Correct, high confidence: nothing.
    issue(op_br, 32'h6c, 1'b1, 32'h1000, 1'b1, 32'h1000, 8'h41);
    chk("hc_flush", {31'd0, flush}, 32'd0);

    // Predicted taken, actually not taken.
    issue(op_br, 32'h70, 1'b0, 32'h2000, 1'b1, 32'h2000, 8'h41);
    chk("nt_flush", {31'd0, flush}, 32'd1);
    chk("nt_redirect", redirect_pc, 32'h74);
    chk("nt_btb_wr", {31'd0, btb_wr}, 32'd0);
    idle();

    // JAL predicted not taken: redirect + BTB write, never trains.
    issue(op_jal, 32'h90, 1'b0, 32'h400, 1'b0, 32'h0, 8'h00);
    chk("jal_flush", {31'd0, flush}, 32'd1);
    chk("jal_redirect", redirect_pc, 32'h400);
    chk("jal_btb_wr", {31'd0, btb_wr}, 32'd1);
    chk("jal_btb_pc", btb_wr_pc, 32'h90);
    idle();

    pop_expect(32'h5c, 1'b1, 8'h01);
    pop_expect(32'h68, 1'b1, 8'hF6);
    pop_expect(32'h70, 1'b0, 8'h41);
    chk("drain1_empty", {31'd0, train_valid}, 32'd0);
    train_ready = 1'b0;

    // Threshold boundaries: 37 and -37 train, 38 and -128 do not.
    issue(op_br, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 8'h25);
    issue(op_br, 32'h304, 1'b0, 32'h0, 1'b0, 32'h0, 8'h26);
    issue(op_br, 32'h308, 1'b0, 32'h0, 1'b0, 32'h0, 8'h80);
    issue(op_br, 32'h30c, 1'b0, 32'h0, 1'b0, 32'h0, 8'hDB);
    pop_expect(32'h300, 1'b0, 8'h25);
    pop_expect(32'h30c, 1'b0, 8'hDB);
    chk("drain2_empty", {31'd0, train_valid}, 32'd0);
    train_ready = 1'b0;

    // Five pushes into a 4-entry queue with no consumer: fifth is dropped.
    for (int i = 0; i < 5; i++) begin
      issue(op_br, 32'h200 + 32'(4 * i), 1'b0, 32'h0, 1'b0, 32'h0, 8'(i));
    end
    for (int i = 0; i < 4; i++) begin
      pop_expect(32'h200 + 32'(4 * i), 1'b0, 8'(i));
    end
    chk("drain3_empty", {31'd0, train_valid}, 32'd0);
    train_ready = 1'b0;

`ifdef BR_RESOLVE_PERF_EN
    chk("perf_branches", n_branches, 32'd15);
    chk("perf_dir_miss", n_dir_miss, 32'd3);
    chk("perf_tgt_miss", n_tgt_miss, 32'd1);
    chk("perf_train_drop", n_train_drop, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/br_resolve_unit.md
Name: br_resolve_unit

Overview:
- EX/MEM-stage branch resolution and predictor-training source; it is the producer end of the `pbp` prediction/training interface.
- Each cycle it compares the EX/MEM branch outcome against the IF-stage prediction carried down the pipe (`bp_br_en`, `bp_target`, `y_out`).
- It issues a registered flush/redirect to fetch on any misprediction.
- It queues perceptron training requests in a small FIFO, drained to `pbp` over a valid/ready handshake.

Parameters:
- w_bits, 8, width of signed perceptron output y_out
- hist_len, 12, global history length; sets training threshold THETA = (193*hist_len)/100 + 14 (integer) = 37 at default
- q_depth, 4, training FIFO entries (power of 2, >= 2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- exmem_valid  in  1  EX/MEM holds a real instruction
- exmem_pc  in  32  PC of EX/MEM instruction
- exmem_opcode  in  rv32i_types::opcode_t  opcode
- exmem_br_en  in  1  actual branch outcome (op_br only)
- exmem_alu_out  in  32  actual target address
- exmem_bp_br_en  in  1  predicted direction
- exmem_bp_target  in  32  predicted target
- exmem_y_out  in  w_bits  signed perceptron output at predict time
- flush  out  1  squash IF/ID/EX next cycle
- redirect_pc  out  32  fetch PC when flush=1
- btb_wr  out  1  write BTB entry
- btb_wr_pc  out  32  BTB index PC
- btb_wr_target  out  32  BTB target
- train_valid  out  1  FIFO head valid
- train_ready  in  1  pbp accepts head
- train_pc  out  32  head PC
- train_taken  out  1  head actual outcome
- train_y_out  out  w_bits  head y_out

Behaviour:
- Reset (synchronous): flush=0, redirect_pc=0, btb_wr=0, btb_wr_pc=0, btb_wr_target=0, FIFO empty (train_valid=0, train_pc=0, train_taken=0, train_y_out=0), FSM=RUN.
- Evaluation only when exmem_valid=1, FSM=RUN, and opcode is op_br, op_jal or op_jalr.
- Actual taken (`act`): exmem_br_en for op_br; 1 for op_jal/op_jalr.
- Actual target (`tgt`): exmem_alu_out.
- dir_miss = act != exmem_bp_br_en.
- tgt_miss = act & exmem_bp_br_en & (tgt != exmem_bp_target).
- Flush: on dir_miss|tgt_miss, next cycle flush=1 (one-cycle pulse, registered).
  - redirect_pc = tgt if act, else exmem_pc+4.
- BTB write: on act & (dir_miss|tgt_miss), next cycle btb_wr=1 with btb_wr_pc=exmem_pc, btb_wr_target=tgt.
- Training (op_br only): push when dir_miss | (|y_out| <= THETA).
  - |y_out| is computed in w_bits+1 bits so -2^(w_bits-1) does not overflow.
  - tgt_miss alone never trains.
  - Pushed entry: {exmem_pc, exmem_br_en, exmem_y_out}.
- FSM:
  - RUN→SHADOW when flush is registered.
  - SHADOW ignores the EX/MEM instruction for exactly one cycle (it is the wrong path), then →RUN.
  - Reset in SHADOW → RUN.
- FIFO:
  - Pop on train_valid & train_ready.
  - Push and pop in the same cycle are both performed, and count is unchanged.
  - At full: push is accepted only if a pop occurs the same cycle; otherwise the new request is dropped (no stall; training is best-effort).
  - Pointers wrap modulo q_depth.
  - Head outputs are taken directly from FIFO storage.
- Latency: resolution → flush/btb_wr is 1 cycle; push → train_valid is 1 cycle (entry visible the cycle after push).

Optional Feature:
- Macro: BR_RESOLVE_PERF_EN.
- With the macro defined:
  - Adds 32-bit counters n_branches, n_dir_miss, n_tgt_miss, n_train_drop, all saturating and reset to 0.
  - Adds output ports of the same names, each 32 bits.
  - Counters increment on the same conditions as above.
- Without the macro: neither the ports nor the logic exist.

Decomposition:
- rv32i_types already provides opcode_t. Add `pbp_types`:
  - THETA function(hist_len)
  - `pbp_train_t` struct {pc, taken, y_out}
  - resolve state enum {RUN, SHADOW}
- One sub-module: `train_fifo` (parameterized sync FIFO of `pbp_train_t`, valid/ready output).

Test Plan:
- Direction miss: op_br, pc=0x5c, br_en=1, bp_br_en=0, alu_out=0xDEADBEEF, y_out=1 → next cycle:
  - flush=1, redirect_pc=0xDEADBEEF, btb_wr=1
  - one training push {0x5c, 1, 0x01}, train_valid=1 the following cycle
  - SHADOW ignores the next instruction
- Target miss: pc=0x60, br_en=1, bp_br_en=1, bp_target=0xDEADBEEF, alu_out=0xDEADA55B, y_out=0x41 (65 > 37) → flush=1, redirect_pc=0xDEADA55B, btb_wr=1, no push.
- Correct, low confidence: pc=0x68, br_en=bp_br_en=1, targets equal, y_out=0xF6 (-10, |10| <= 37) → no flush, one push.
- Correct, high confidence: y_out=0x41 → no flush, no push.
- Predicted taken, actually not taken: pc=0x70, br_en=0, bp_br_en=1 → flush, redirect_pc=0x74, btb_wr=0, push.
- FIFO full: hold train_ready=0 with 5 training pushes → first 4 retained, 5th dropped (n_train_drop=1 if PERF_EN); then train_ready=1 drains in FIFO order, 4 handshakes.
